// File: rtl/fault_seq_pkg.sv
// fault_seq_pkg: shared state encoding and sa_mask layout for the fault sequencer.
package fault_seq_pkg;
  typedef enum logic [2:0] {IDLE, GOLDEN, SA0, SA1, DONE} state_e;
  localparam int MASK_SA0 = 0;
  localparam int MASK_SA1 = 1;
  function automatic state_e first_pass(input logic [1:0] mask);
    return mask[MASK_SA0] ? SA0 : mask[MASK_SA1] ? SA1 : DONE;
  endfunction
endpackage

// File: rtl/fault_dwell_cnt.sv
// fault_dwell_cnt: DWELL-modulo strobe counter; wrap marks the strobe that ends a dwell.
module fault_dwell_cnt #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic wrap
);
  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap = inc && !clr && (cnt_q == W'(DWELL - 1));
  always_comb cnt_d = (clr || wrap) ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fault_seq_ctrl.sv
// fault_seq_ctrl: sequences golden, stuck-at-0 and stuck-at-1 passes over NSITES fault sites.
module fault_seq_ctrl
  import fault_seq_pkg::*;
#(
  parameter int NSITES = 10,
  parameter int DWELL = 1,
  parameter int GOLDEN_EN = 1,
  localparam int IDXW = (NSITES > 1) ? $clog2(NSITES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        sa_mask,
  input  logic              INC,
  output logic [NSITES-1:0] FEN,
  output logic              fault,
  output logic              golden,
  output logic              busy,
  output logic [IDXW-1:0]   fault_idx,
  output logic              END
);
  state_e state_q, state_d;
  logic [1:0] mask_q, mask_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NSITES-1:0] fen_q;
  logic fault_q, golden_q, busy_q, end_q;
  logic start_acc, running, last, wrap;
  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign running = state_q == GOLDEN || state_q == SA0 || state_q == SA1;
  assign last = idx_q == IDXW'(NSITES - 1);
  fault_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .inc (INC && running && !abort),
    .clr (abort || start_acc),
    .wrap(wrap)
  );
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    idx_d = idx_q;
    case (state_q)
      IDLE, DONE: if (start_acc) begin
        mask_d = sa_mask;
        idx_d = '0;
        state_d = (GOLDEN_EN != 0) ? GOLDEN : first_pass(sa_mask);
      end
      GOLDEN: if (wrap) state_d = first_pass(mask_q);
      SA0, SA1: if (wrap) begin
        idx_d = last ? '0 : idx_q + IDXW'(1);
        if (last) state_d = (state_q == SA0 && mask_q[MASK_SA1]) ? SA1 : DONE;
      end
      default: begin
        state_d = IDLE;
        idx_d = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d = '0;
    end
  end
  // Outputs are computed from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      idx_q <= '0;
      fen_q <= '0;
      fault_q <= 1'b0;
      golden_q <= 1'b0;
      busy_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      fen_q <= (state_d == SA0 || state_d == SA1) ? NSITES'(1) << idx_d : '0;
      fault_q <= state_d == SA1;
      golden_q <= state_d == GOLDEN;
      busy_q <= state_d == GOLDEN || state_d == SA0 || state_d == SA1;
      end_q <= state_d == DONE;
    end
  end
  assign FEN = fen_q;
  assign fault = fault_q;
  assign golden = golden_q;
  assign busy = busy_q;
  assign fault_idx = idx_q;
  assign END = end_q;
endmodule

// File: tb/tb_fault_seq_ctrl.sv
// tb_fault_seq_ctrl: two configurations driven in lockstep and checked against a step-list model.
module tb_fault_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic inc = 1'b0;
  logic [1:0] mask = 2'b00;
  logic [9:0] a_fen;
  logic [3:0] a_idx;
  logic a_flt, a_gld, a_busy, a_end;
  logic [3:0] b_fen;
  logic [1:0] b_idx;
  logic b_flt, b_gld, b_busy, b_end;
  int errors = 0;
  int checks = 0;
  int p_n[2] = '{10, 4};
  int p_d[2] = '{1, 3};
  int p_g[2] = '{1, 0};
  logic [15:0] s_fen[2][32];
  int s_idx[2][32];
  logic s_flt[2][32];
  logic s_gld[2][32];
  int len[2], pos[2], cnt[2], mode[2];
  bit found;

  always #5 clk = ~clk;

  fault_seq_ctrl u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sa_mask(mask), .INC(inc),
    .FEN(a_fen), .fault(a_flt), .golden(a_gld), .busy(a_busy), .fault_idx(a_idx), .END(a_end)
  );
  fault_seq_ctrl #(.NSITES(4), .DWELL(3), .GOLDEN_EN(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sa_mask(mask), .INC(inc),
    .FEN(b_fen), .fault(b_flt), .golden(b_gld), .busy(b_busy), .fault_idx(b_idx), .END(b_end)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // A campaign is the ordered list of (FEN, index, polarity, golden) steps, each held DWELL INCs.
  task automatic build(input int k, input logic [1:0] m);
    len[k] = 0;
    if (p_g[k] != 0) begin
      s_fen[k][0] = 16'h0; s_idx[k][0] = 0; s_flt[k][0] = 1'b0; s_gld[k][0] = 1'b1;
      len[k] = 1;
    end
    for (int p = 0; p < 2; p++)
      if (m[p])
        for (int s = 0; s < p_n[k]; s++) begin
          s_fen[k][len[k]] = 16'h1 << s;
          s_idx[k][len[k]] = s;
          s_flt[k][len[k]] = p[0];
          s_gld[k][len[k]] = 1'b0;
          len[k]++;
        end
  endtask

  function automatic logic [31:0] exp_of(input int k);
    if (mode[k] == 2) return 32'h1;
    if (mode[k] == 0) return 32'h0;
    return {4'h0, s_fen[k][pos[k]], 8'(s_idx[k][pos[k]]), s_flt[k][pos[k]], s_gld[k][pos[k]], 1'b1, 1'b0};
  endfunction

  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mode[k] = 0; pos[k] = 0; cnt[k] = 0;
      end else if (abort) mode[k] = 0;
      else if (mode[k] != 1 && start) begin
        build(k, mask);
        pos[k] = 0; cnt[k] = 0;
        mode[k] = (len[k] == 0) ? 2 : 1;
      end else if (mode[k] == 1 && inc) begin
        cnt[k]++;
        if (cnt[k] == p_d[k]) begin
          cnt[k] = 0;
          pos[k]++;
          if (pos[k] == len[k]) mode[k] = 2;
        end
      end
    end

  always @(negedge clk) begin
    chk("cfgA", {4'h0, 16'(a_fen), 8'(a_idx), a_flt, a_gld, a_busy, a_end}, exp_of(0));
    chk("cfgB", {4'h0, 16'(b_fen), 8'(b_idx), b_flt, b_gld, b_busy, b_end}, exp_of(1));
    checks++;
    assert ($onehot0(a_fen) && $onehot0(b_fen)) else begin
      errors++;
      $display("FAIL onehot: a_fen=%h b_fen=%h", a_fen, b_fen);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a", 32'({a_fen, a_idx, a_flt, a_gld, a_busy, a_end}), 32'h0);
    rst = 1'b0;
    // campaign 1: defaults, both passes, INC held high
    @(negedge clk); mask = 2'b11; start = 1'b1; inc = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t1_golden", 32'({a_gld, a_busy, a_fen}), 32'({1'b1, 1'b1, 10'h0}));
    chk("t1_b_first", 32'({b_busy, b_fen}), 32'({1'b1, 4'h1}));
    @(negedge clk);
    chk("t1_sa0_first", 32'({a_flt, a_fen}), 32'({1'b0, 10'h001}));
    repeat (9) @(negedge clk);
    chk("t1_sa0_last", 32'({a_flt, a_idx, a_fen}), 32'({1'b0, 4'd9, 10'h200}));
    @(negedge clk);
    chk("t1_sa1_first", 32'({a_flt, a_idx, a_fen}), 32'({1'b1, 4'd0, 10'h001}));
    repeat (9) @(negedge clk);
    chk("t1_sa1_last", 32'({a_end, a_flt, a_fen}), 32'({1'b0, 1'b1, 10'h200}));
    @(negedge clk);
    chk("t1_end", 32'({a_end, a_busy, a_fen}), 32'({1'b1, 1'b0, 10'h0}));
    repeat (4) @(negedge clk);
    inc = 1'b0;
    // campaign 2: SA0 only, B holds each site for three INCs
    @(negedge clk); mask = 2'b01; start = 1'b1; inc = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t2_b0", 32'(b_fen), 32'h1);
    repeat (3) @(negedge clk);
    chk("t2_b1", 32'(b_fen), 32'h2);
    repeat (8) @(negedge clk);
    chk("t2_b3", 32'({b_end, b_fen}), 32'({1'b0, 4'h8}));
    @(negedge clk);
    chk("t2_bend", 32'({b_end, b_flt, b_fen}), 32'({1'b1, 1'b0, 4'h0}));
    inc = 1'b0;
    // campaign 3: SA1 only, then empty mask
    @(negedge clk); mask = 2'b10; start = 1'b1; inc = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t3_b_sa1", 32'({b_flt, b_fen}), 32'({1'b1, 4'h1}));
    @(negedge clk);
    chk("t3_a_sa1", 32'({a_gld, a_flt, a_fen}), 32'({1'b0, 1'b1, 10'h001}));
    repeat (12) @(negedge clk);
    inc = 1'b0; mask = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t3_b_empty", 32'({b_end, b_busy}), 32'({1'b1, 1'b0}));
    chk("t3_a_golden", 32'({a_gld, a_end}), 32'({1'b1, 1'b0}));
    inc = 1'b1;
    @(negedge clk); inc = 1'b0;
    chk("t3_a_end", 32'(a_end), 32'h1);
    // abort mid-SA1 at site 5 together with start and INC
    mask = 2'b11; start = 1'b1; inc = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (a_idx == 4'd5 && a_flt) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t4_reach: site 5 of SA1 not reached, idx=%0d fault=%b", a_idx, a_flt);
    end
    start = 1'b1; abort = 1'b1; mask = 2'b01;
    @(negedge clk); start = 1'b0; abort = 1'b0; inc = 1'b0;
    chk("t4_abort", 32'({a_busy, a_end, a_gld, a_fen}), 32'h0);
    mask = 2'b11; start = 1'b1;
    @(negedge clk); mask = 2'b01; inc = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t4_ignore", 32'({a_gld, a_flt, a_fen}), 32'({1'b0, 1'b0, 10'h001}));
    // asynchronous reset between edges mid-SA0
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("t5_async_a", 32'({a_fen, a_idx, a_flt, a_gld, a_busy, a_end}), 32'h0);
    chk("t5_async_b", 32'({b_fen, b_idx, b_flt, b_gld, b_busy, b_end}), 32'h0);
    @(negedge clk); inc = 1'b0;
    @(negedge clk); rst = 1'b0; mask = 2'b11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t5_restart", 32'({a_gld, a_busy}), 32'({1'b1, 1'b1}));
    // random INC gaps, starts, aborts and masks
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      inc = $urandom_range(0, 2) != 0;
      start = $urandom_range(0, 40) == 0;
      abort = $urandom_range(0, 150) == 0;
      mask = 2'($urandom);
    end
    @(negedge clk); start = 1'b0; abort = 1'b0; inc = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
